id_stage_scoreboard: RTL
========================

// Module: id_stage_scoreboard
// PURPOSE
//  Parametrised decode stage: field extraction, immediate generation, regfile read.
//  Adds NUM_WB write-back ports with same-cycle forwarding and a busy-bit scoreboard with stall.
//  Output is a registered ID/EX slot with valid/ready handshake and flush.
//  Sits between the fetch stage (IF/ID) and execute; the regfile lives inside this block.
// PARAMETERS
//  XLEN      32  datapath / register width
//  NREG      32  architectural registers; x0 hardwired to 0; RW = $clog2(NREG)
//  NUM_WB    2   write-back ports; a higher index has priority on a same-rd collision
//  SB_LOADS  1   1: scoreboard tracks only loads (op 0000011); 0: tracks every rd != 0 writer
// PORTS
//  clk           in   1            clock, rising edge
//  rst           in   1            asynchronous, active-low reset
//  flush         in   1            kill the in-flight input and the output slot (branch/jump redirect)
//  in_valid      in   1            in_ir/in_pc hold a valid instruction
//  in_ready      out  1            stage accepts the input this cycle
//  in_ir         in   32           instruction word
//  in_pc         in   XLEN         instruction PC
//  wb_we         in   NUM_WB       per-port write enable
//  wb_rd         in   NUM_WB*RW    per-port destination register, packed
//  wb_data       in   NUM_WB*XLEN  per-port write data, packed
//  out_valid     out  1            ID/EX slot holds a valid instruction
//  out_ready     in   1            execute consumes the slot
//  out_pc        out  XLEN         registered PC
//  out_ir        out  32           registered instruction
//  out_rs1/rs2   out  RW each      source indices; 0 when the source is unused
//  out_rd        out  RW           destination; 0 for store/branch
//  out_rs1_data  out  XLEN         operand 1, forwarded
//  out_rs2_data  out  XLEN         operand 2, forwarded
//  out_imm       out  XLEN         immediate selected by opcode format (I/S/B/U/J; 0 for R-type)
//  stall         out  1            hazard indicator (in_valid && hazard)
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, busy[] cleared, all registers 0; in_ready=1 once released.
//  Source decode: rs1 forced to 0 for LUI/AUIPC/JAL.
//  Source decode: rs2 forced to 0 for LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/SYSTEM.
//  Source decode: rd forced to 0 for STORE/BRANCH.
//  A source is "used" only when its index != 0.
//  Tracked instruction: rd != 0 && (SB_LOADS ? opcode==LOAD : 1).
//  Hazard: a used rs matches either of:
//    - busy[rs] with no same-cycle wb_we clearing that rs;
//    - out_valid && out_rd==rs && the out-slot instruction is tracked.
//  in_ready = !hazard && (!out_valid || out_ready) && !flush.
//  Accept (in_valid && in_ready): slot loaded on the next edge; out_valid=1. Latency is 1 cycle.
//  Slot holds: out_* stay stable while out_valid && !out_ready.
//  Slot drain: out_valid drops to 0 on drain with no new accept.
//  Write: each wb port with wb_we && rd!=0 writes the regfile at the edge.
//  Write collisions: the highest port index wins; writes to x0 are ignored.
//  Forwarding: the read uses same-cycle wb_data when wb_we && wb_rd==rs, highest index winning.
//  x0 always reads 0.
//  Scoreboard set: busy[out_rd] is set when a tracked slot leaves (out_valid && out_ready).
//  Scoreboard clear: busy[r] is cleared by any wb_we with wb_rd==r.
//  Set+clear on the same r in one cycle: set wins (the newer writer).
//  Flush: out_valid is 0 next cycle and the input is not accepted.
//  Flush does not alter busy[]: already-issued instructions are older and still write back.
//  Flush has priority over out_ready.
//  Reset mid-operation: all state returns to reset values immediately; pending busy bits are lost.
//  Immediates are sign-extended from bit 31 as RV32I; U = {ir[31:12],12'b0}.
// TESTING
//  1. ADDI x1,x0,5 with out_ready=1 -> next cycle out_valid=1, out_rd=1, out_imm=5, out_rs2=0.
//  2. WB x3=0xDEAD on port0 while ADD x4,x3,x3 is accepted -> out_rs1_data=out_rs2_data=0xDEAD.
//  3. Ports 0 and 1 both write x5 (0x11, 0x22) same cycle -> later reads of x5 return 0x22.
//  4. SB_LOADS=1: LW x6 issues, then ADD x7,x6,x0 -> stall=1 and in_ready=0 until wb_we x6.
//  5. Continued from 4: the WB cycle accepts with the forwarded value.
//  6. out_ready=0 for 3 cycles -> slot stable and in_ready=0; flush -> out_valid=0, busy[] unchanged.
//  7. Async reset asserted mid-stall -> outputs 0 and busy cleared the same cycle.
//  8. Write to x0 -> reads still 0 and no stall.

Source files
------------

// File: rtl/id_stage_scoreboard.sv
// Decode stage: field extraction, immediates, in-block regfile with NUM_WB forwarded
// write-back ports, busy-bit scoreboard and a registered ID/EX slot with flush.

// Per-source read path: regfile read, same-cycle write-back forwarding and hazard test.
module id_stage_src #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NUM_WB = 2,
    parameter int RW     = 5
) (
    input  logic [RW-1:0]                  rs,
    input  logic [NREG-1:0][XLEN-1:0]      rf,
    input  logic [NREG-1:0]                busy,
    input  logic [NUM_WB-1:0]              wb_we,
    input  logic [NUM_WB-1:0][RW-1:0]      wb_rd,
    input  logic [NUM_WB-1:0][XLEN-1:0]    wb_data,
    input  logic                           slot_trk,
    input  logic [RW-1:0]                  slot_rd,
    output logic [XLEN-1:0]                data,
    output logic                           hazard
);
    logic wb_hit;

    // Ascending scan: the last matching port (highest index) wins.
    always_comb begin
        data   = rf[rs];
        wb_hit = 1'b0;
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_we[p] && (wb_rd[p] == rs)) begin
                data   = wb_data[p];
                wb_hit = 1'b1;
            end
        end
        if (rs == '0) data = '0;
    end

    assign hazard = (rs != '0) &&
                    ((busy[rs] && !wb_hit) || (slot_trk && (slot_rd == rs)));
endmodule

module id_stage_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NUM_WB   = 2,
    parameter int SB_LOADS = 1,
    localparam int RW      = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_ir,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [NUM_WB-1:0]       wb_we,
    input  logic [NUM_WB*RW-1:0]    wb_rd,
    input  logic [NUM_WB*XLEN-1:0]  wb_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [31:0]             out_ir,
    output logic [RW-1:0]           out_rs1,
    output logic [RW-1:0]           out_rs2,
    output logic [RW-1:0]           out_rd,
    output logic [XLEN-1:0]         out_rs1_data,
    output logic [XLEN-1:0]         out_rs2_data,
    output logic [XLEN-1:0]         out_imm,
    output logic                    stall
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     ir;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
    } slot_t;

    slot_t                           slot;
    logic                            slot_v;
    logic [NREG-1:0][XLEN-1:0]       rf;
    logic [NREG-1:0]                 busy, busy_nxt;
    logic [NUM_WB-1:0][RW-1:0]       wb_rd_a;
    logic [NUM_WB-1:0][XLEN-1:0]     wb_data_a;
    logic [6:0]                      opc;
    logic [1:0][RW-1:0]              dec_rs;
    logic [RW-1:0]                   dec_rd;
    logic [XLEN-1:0]                 dec_imm;
    logic [1:0][XLEN-1:0]            src_data;
    logic [1:0]                      src_haz;
    logic                            hazard, slot_trk, accept, leave;

    assign wb_rd_a   = wb_rd;
    assign wb_data_a = wb_data;

    always_comb begin
        opc       = in_ir[6:0];
        dec_rs[0] = in_ir[15 +: RW];
        dec_rs[1] = in_ir[20 +: RW];
        dec_rd    = in_ir[7 +: RW];
        dec_imm   = '0;
        if (opc inside {OP_LUI, OP_AUIPC, OP_JAL})
            dec_rs[0] = '0;
        if (opc inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM})
            dec_rs[1] = '0;
        if (opc inside {OP_STORE, OP_BRANCH})
            dec_rd = '0;
        case (opc)
            OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM:
                dec_imm = {{(XLEN-11){in_ir[31]}}, in_ir[30:20]};
            OP_STORE:
                dec_imm = {{(XLEN-11){in_ir[31]}}, in_ir[30:25], in_ir[11:7]};
            OP_BRANCH:
                dec_imm = {{(XLEN-12){in_ir[31]}}, in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                dec_imm = {{(XLEN-31){in_ir[31]}}, in_ir[30:12], 12'b0};
            OP_JAL:
                dec_imm = {{(XLEN-20){in_ir[31]}}, in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
            default:
                dec_imm = '0;
        endcase
    end

    // Only a tracked writer sitting in the slot blocks its consumers; others are forwarded in EX.
    assign slot_trk = slot_v && (slot.rd != '0) &&
                      ((SB_LOADS == 0) || (slot.ir[6:0] == OP_LOAD));

    for (genvar s = 0; s < 2; s++) begin : g_src
        id_stage_src #(
            .XLEN(XLEN), .NREG(NREG), .NUM_WB(NUM_WB), .RW(RW)
        ) u_src (
            .rs       (dec_rs[s]),
            .rf       (rf),
            .busy     (busy),
            .wb_we    (wb_we),
            .wb_rd    (wb_rd_a),
            .wb_data  (wb_data_a),
            .slot_trk (slot_trk),
            .slot_rd  (slot.rd),
            .data     (src_data[s]),
            .hazard   (src_haz[s])
        );
    end

    assign hazard   = |src_haz;
    assign stall    = in_valid && hazard;
    assign in_ready = rst && !hazard && (!slot_v || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    // A flushed slot is killed, not consumed, so it never sets a busy bit.
    assign leave    = slot_v && out_ready && !flush;

    always_comb begin
        busy_nxt = busy;
        for (int p = 0; p < NUM_WB; p++)
            if (wb_we[p]) busy_nxt[wb_rd_a[p]] = 1'b0;
        if (leave && slot_trk) busy_nxt[slot.rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy <= '0;
        else      busy <= busy_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf <= '0;
        end else begin
            for (int p = 0; p < NUM_WB; p++)
                if (wb_we[p] && (wb_rd_a[p] != '0)) rf[wb_rd_a[p]] <= wb_data_a[p];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_v <= 1'b0;
            slot   <= '0;
        end else if (accept) begin
            slot_v        <= 1'b1;
            slot.pc       <= in_pc;
            slot.ir       <= in_ir;
            slot.rs1      <= dec_rs[0];
            slot.rs2      <= dec_rs[1];
            slot.rd       <= dec_rd;
            slot.rs1_data <= src_data[0];
            slot.rs2_data <= src_data[1];
            slot.imm      <= dec_imm;
        end else if (flush || out_ready) begin
            slot_v <= 1'b0;
        end
    end

    assign out_valid    = slot_v;
    assign out_pc       = slot.pc;
    assign out_ir       = slot.ir;
    assign out_rs1      = slot.rs1;
    assign out_rs2      = slot.rs2;
    assign out_rd       = slot.rd;
    assign out_rs1_data = slot.rs1_data;
    assign out_rs2_data = slot.rs2_data;
    assign out_imm      = slot.imm;
endmodule
